inha_cmd_ctrl: RTL and testbench

INHA_CMD_CTRL -- requirements
Module: inha_cmd_ctrl

---
 rtl/inha_pkg.sv | 60 ++++++
 rtl/inha_cmd_ctrl_debounce.sv | 55 +++++
 rtl/inha_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_inha_cmd_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/inha_pkg.sv
// inha_pkg: shared command codes, mode encodings, lamp mapping and the
// round-robin pick helper used by the command controller.
package inha_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_PAUSE = 2'd2,
        MODE_OVER  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        CMD_LEFT   = 3'd0,
        CMD_RIGHT  = 3'd1,
        CMD_UP     = 3'd2,
        CMD_DOWN   = 3'd3,
        CMD_SELECT = 3'd4
    } cmd_e;

    localparam int unsigned NUM_CMDS = 5;

    // Lamp vectors ordered {RD, GN, YL}
    localparam logic [2:0] LAMP_IDLE  = 3'b001;
    localparam logic [2:0] LAMP_PLAY  = 3'b010;
    localparam logic [2:0] LAMP_PAUSE = 3'b011;
    localparam logic [2:0] LAMP_OVER  = 3'b100;

    function automatic logic [2:0] mode_lamps(input mode_e m);
        logic [2:0] l;
        case (m)
            MODE_IDLE:  l = LAMP_IDLE;
            MODE_PLAY:  l = LAMP_PLAY;
            MODE_PAUSE: l = LAMP_PAUSE;
            MODE_OVER:  l = LAMP_OVER;
            default:    l = '0;
        endcase
        return l;
    endfunction

    // Returns {found, code}: first set request searching upward from start,
    // wrapping modulo NUM_CMDS.
    function automatic logic [3:0] rr_pick(input logic [NUM_CMDS-1:0] req,
                                           input logic [2:0] start);
        logic [3:0]  res;
        int unsigned idx;
        res = '0;
        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            idx = (32'(start) + i) % NUM_CMDS;
            if (!res[3] && req[idx]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] c);
        return (32'(c) == NUM_CMDS - 1) ? 3'd0 : c + 3'd1;
    endfunction

endpackage

// File: rtl/inha_cmd_ctrl_debounce.sv
// inha_debounce: 2-flop synchronizer, hold-time debouncer and a registered
// one-cycle pulse on each debounced high-to-low transition.
module inha_debounce
    import inha_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic fall_o
);

    localparam int unsigned    CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips once the synchronized input has disagreed for DEB_CYCLES samples
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_d = deb_q & ~deb_d;
    end

    // Synchronizer, debounce state and fall pulse registers; released level is 1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/inha_cmd_ctrl.sv
// inha_cmd_ctrl: debounced button/switch front end, game mode FSM and a
// round-robin command offer with valid/ready handshake.
// Optional: define INHA_DROP_CNT_EN to build the saturating drop counter;
// otherwise drop_cnt is tied to zero.
module inha_cmd_ctrl
    import inha_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    input  logic [3:0] sw_n,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_code,
    output logic [1:0] mode,
    output logic       RD,
    output logic       GN,
    output logic       YL,
    output logic [7:0] drop_cnt
);

    logic [7:0]          raw_n;
    logic [7:0]          press;
    logic [3:0]          sw_press;
    logic [NUM_CMDS-1:0] cmd_src;

    mode_e               mode_q, mode_d;
    logic [NUM_CMDS-1:0] pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [2:0]          code_q, code_d;
    logic [2:0]          ptr_q, ptr_d;

    logic                accept, in_play, stay_play;
    logic [NUM_CMDS-1:0] onehot, clr_mask, offer_mask, req, drop_mask, avail;
    logic [3:0]          pick;

    assign raw_n    = {sw_n, btn_n};
    assign sw_press = press[7:4];
    // Command code equals bit position: buttons L/R/U/D then SW2 as SELECT
    assign cmd_src  = {sw_press[2], press[3:0]};

    for (genvar g = 0; g < 8; g++) begin : g_deb
        inha_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i  (clk),
            .rst_i  (rst),
            .din_i  (raw_n[g]),
            .fall_o (press[g])
        );
    end

    // Mode transitions; SW3 outranks SW1, SW0 only acts in IDLE/OVER
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_IDLE:  if (sw_press[0]) mode_d = MODE_PLAY;
            MODE_PLAY: begin
                if (sw_press[3])      mode_d = MODE_OVER;
                else if (sw_press[1]) mode_d = MODE_PAUSE;
            end
            MODE_PAUSE: begin
                if (sw_press[3])      mode_d = MODE_OVER;
                else if (sw_press[1]) mode_d = MODE_PLAY;
            end
            MODE_OVER:  if (sw_press[0]) mode_d = MODE_IDLE;
            default:    mode_d = MODE_IDLE;
        endcase
    end

    // Pending set/clear, drop detection and round-robin offer selection
    always_comb begin
        accept     = valid_q & cmd_ready;
        in_play    = (mode_q == MODE_PLAY);
        stay_play  = in_play && (mode_d == MODE_PLAY);
        onehot     = NUM_CMDS'(1) << code_q;
        clr_mask   = accept ? onehot : '0;
        offer_mask = (valid_q && !accept) ? onehot : '0;
        req        = in_play ? cmd_src : '0;
        // A press merges into an existing pending bit or a still-open offer;
        // the bit being cleared this edge is free to be re-armed.
        drop_mask  = req & ((pend_q & ~clr_mask) | offer_mask);
        pend_d     = stay_play ? ((pend_q & ~clr_mask) | (req & ~drop_mask)) : '0;
        avail      = pend_q & ~clr_mask;
        pick       = rr_pick(avail, ptr_q);
        valid_d    = valid_q & ~accept;
        code_d     = code_q;
        ptr_d      = ptr_q;
        if ((!valid_q || accept) && stay_play && pick[3]) begin
            valid_d = 1'b1;
            code_d  = pick[2:0];
            ptr_d   = rr_next(pick[2:0]);
        end
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= CMD_LEFT;
            ptr_q   <= CMD_LEFT;
        end else begin
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef INHA_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of merged presses, one step per dropped source
    always_comb begin
        drop_d = drop_q;
        for (int unsigned i = 0; i < NUM_CMDS; i++) begin
            if (drop_mask[i] && drop_d != 8'hFF) begin
                drop_d = drop_d + 8'd1;
            end
        end
    end

    // Drop counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign cmd_valid    = valid_q;
    assign cmd_code     = code_q;
    assign mode         = mode_q;
    assign {RD, GN, YL} = mode_lamps(mode_q);

endmodule

// File: tb/tb_inha_cmd_ctrl.sv
// tb_inha_cmd_ctrl: directed stimulus for inha_cmd_ctrl with a scoreboard of
// expected command codes checked at each accepted handshake.
module tb_inha_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] btn_n;
    logic [3:0] sw_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic [1:0] mode;
    logic       RD, GN, YL;
    logic [7:0] drop_cnt;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_code;
    logic [7:0] exp_drop;

    inha_cmd_ctrl #(.DEB_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .sw_n      (sw_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .mode      (mode),
        .RD        (RD),
        .GN        (GN),
        .YL        (YL),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one active-low button for a single sampled cycle
    task automatic press_btn(input int idx);
        btn_n[idx] = 1'b0;
        tick(1);
        btn_n[idx] = 1'b1;
    endtask

    task automatic press_sw(input int idx);
        sw_n[idx] = 1'b0;
        tick(1);
        sw_n[idx] = 1'b1;
    endtask

    task automatic ready_pulse();
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
    endtask

    // Scoreboard: every accepted command must match the next expected code
    always @(negedge clk) begin
        if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 8'(cmd_code), 8'hFF);
            end else begin
                exp_code = exp_q.pop_front();
                chk("cmd_code_sb", 8'(cmd_code), 8'(exp_code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef INHA_DROP_CNT_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
`endif
        rst = 1'b1; btn_n = '1; sw_n = '1; cmd_ready = 1'b0;
        tick(2);
        chk("rst_mode",  8'(mode), 8'd0);
        chk("rst_valid", 8'(cmd_valid), 8'd0);
        chk("rst_code",  8'(cmd_code), 8'd0);
        chk("rst_lamps", 8'({RD, GN, YL}), 8'b001);
        chk("rst_drop",  drop_cnt, 8'd0);
        rst = 1'b0;
        tick(1);

        // IDLE -> PLAY, then single UP with ready high: 5-edge latency, 1 cycle wide
        press_sw(0);
        tick(3);
        chk("play_mode",  8'(mode), 8'd1);
        chk("play_lamps", 8'({RD, GN, YL}), 8'b010);
        cmd_ready = 1'b1;
        exp_q.push_back(3'd2);
        press_btn(2);
        tick(3);
        chk("lat_before", 8'(cmd_valid), 8'd0);
        tick(1);
        chk("lat_valid", 8'(cmd_valid), 8'd1);
        chk("lat_code",  8'(cmd_code), 8'd2);
        tick(1);
        chk("lat_width", 8'(cmd_valid), 8'd0);

        // L, U, R one cycle apart with ready low: round-robin gives 0,1,2
        cmd_ready = 1'b0;
        press_btn(0);
        press_btn(2);
        press_btn(1);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        tick(4);
        chk("rr0_valid", 8'(cmd_valid), 8'd1);
        chk("rr0_code",  8'(cmd_code), 8'd0);
        tick(3);
        chk("rr0_hold",  8'(cmd_code), 8'd0);
        ready_pulse();
        chk("rr1_valid", 8'(cmd_valid), 8'd1);
        chk("rr1_code",  8'(cmd_code), 8'd1);
        tick(2);
        chk("rr1_hold",  8'(cmd_code), 8'd1);
        ready_pulse();
        chk("rr2_code",  8'(cmd_code), 8'd2);
        ready_pulse();
        chk("rr_done",   8'(cmd_valid), 8'd0);

        // Three UP presses while offered: one command, two drops
        press_btn(2);
        tick(1);
        press_btn(2);
        tick(1);
        press_btn(2);
        exp_q.push_back(3'd2);
        tick(4);
        chk("merge_valid", 8'(cmd_valid), 8'd1);
        chk("merge_code",  8'(cmd_code), 8'd2);
        chk("merge_drop",  drop_cnt, exp_drop);
        ready_pulse();
        chk("merge_once",  8'(cmd_valid), 8'd0);

        // UP offered, LEFT pending, then PAUSE clears LEFT; UP still completes
        press_btn(2);
        press_btn(0);
        exp_q.push_back(3'd2);
        tick(4);
        chk("pause_pre_code", 8'(cmd_code), 8'd2);
        press_sw(1);
        tick(3);
        chk("pause_mode",  8'(mode), 8'd2);
        chk("pause_lamps", 8'({RD, GN, YL}), 8'b011);
        chk("pause_offer", 8'(cmd_valid), 8'd1);
        ready_pulse();
        chk("pause_done",  8'(cmd_valid), 8'd0);
        press_btn(1);
        tick(3);
        press_sw(1);
        tick(3);
        chk("resume_mode", 8'(mode), 8'd1);
        tick(5);
        chk("no_stale",    8'(cmd_valid), 8'd0);
        chk("drop_steady", drop_cnt, exp_drop);

        // SW1 and SW3 together: SW3 wins -> OVER, then SW0 -> IDLE
        sw_n[1] = 1'b0; sw_n[3] = 1'b0;
        tick(1);
        sw_n = '1;
        tick(3);
        chk("over_mode",  8'(mode), 8'd3);
        chk("over_lamps", 8'({RD, GN, YL}), 8'b100);
        press_sw(0);
        tick(3);
        chk("idle_mode",  8'(mode), 8'd0);
        chk("idle_lamps", 8'({RD, GN, YL}), 8'b001);

        // Reset mid-handshake: DOWN offered, never completed
        press_sw(0);
        tick(3);
        chk("replay_mode", 8'(mode), 8'd1);
        press_btn(3);
        tick(4);
        chk("down_valid", 8'(cmd_valid), 8'd1);
        chk("down_code",  8'(cmd_code), 8'd3);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 8'(cmd_valid), 8'd0);
        chk("arst_mode",  8'(mode), 8'd0);
        chk("arst_code",  8'(cmd_code), 8'd0);
        chk("arst_drop",  drop_cnt, 8'd0);
        chk("arst_lamps", 8'({RD, GN, YL}), 8'b001);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("sb_empty", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
